// File: rtl/regfile_write_arbiter_if.sv
// Two writeback request channels plus the register-file write port they share.
// The master drives the requests and observes the write port; the slave is the arbiter.
interface regfile_write_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  req0_valid;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [DATA_WIDTH-1:0] req0_data;
  logic                  req0_ready;

  logic                  req1_valid;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0] req1_data;
  logic                  req1_ready;

  logic                  wr_enable;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  modport master (
    output req0_valid, req0_addr, req0_data,
    input  req0_ready,
    output req1_valid, req1_addr, req1_data,
    input  req1_ready,
    input  wr_enable, wr_addr, wr_data
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    output req0_ready,
    input  req1_valid, req1_addr, req1_data,
    output req1_ready,
    output wr_enable, wr_addr, wr_data
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the register-file write port: ALU (req0) vs load (req1); one registered
// write stage (handshake to regfile update = 2 edges), ready is combinational and dropped while hold=1.
module regfile_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 hold,
  input  logic                 count_clear,
  regfile_write_arbiter_if.slave bus,
  output logic                 last_grant,
  output logic [CNT_WIDTH-1:0] stall_count0,
  output logic [CNT_WIDTH-1:0] stall_count1
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic                  prio_q, prio_d;
  logic                  last_grant_q, last_grant_d;
  logic                  wr_enable_q, wr_enable_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [CNT_WIDTH-1:0]  stall_count0_q, stall_count0_d;
  logic [CNT_WIDTH-1:0]  stall_count1_q, stall_count1_d;

  logic grant0;
  logic grant1;
  logic stall0;
  logic stall1;

  // reset_n gates the grants so ready stays low for the whole reset interval.
  always_comb begin
    grant0 = reset_n & ~hold & bus.req0_valid & (~bus.req1_valid | ~prio_q);
    grant1 = reset_n & ~hold & bus.req1_valid & (~bus.req0_valid |  prio_q);
    stall0 = bus.req0_valid & ~grant0;
    stall1 = bus.req1_valid & ~grant1;
  end

  always_comb begin
    prio_d       = prio_q;
    last_grant_d = last_grant_q;
    wr_enable_d  = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    if (grant0) begin
      prio_d       = 1'b1;
      last_grant_d = 1'b0;
      wr_addr_d    = bus.req0_addr;
      wr_data_d    = bus.req0_data;
      wr_enable_d  = (bus.req0_addr != '0);
    end else if (grant1) begin
      prio_d       = 1'b0;
      last_grant_d = 1'b1;
      wr_addr_d    = bus.req1_addr;
      wr_data_d    = bus.req1_data;
      wr_enable_d  = (bus.req1_addr != '0);
    end
  end

  // Saturating stall counters; clear wins over a same-cycle increment.
  always_comb begin
    stall_count0_d = stall_count0_q;
    stall_count1_d = stall_count1_q;
    if (count_clear) begin
      stall_count0_d = '0;
      stall_count1_d = '0;
    end else begin
      if (stall0 && (stall_count0_q != CNT_MAX)) begin
        stall_count0_d = stall_count0_q + CNT_ONE;
      end
      if (stall1 && (stall_count1_q != CNT_MAX)) begin
        stall_count1_d = stall_count1_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio_q         <= 1'b0;
      last_grant_q   <= 1'b0;
      wr_enable_q    <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      stall_count0_q <= '0;
      stall_count1_q <= '0;
    end else begin
      prio_q         <= prio_d;
      last_grant_q   <= last_grant_d;
      wr_enable_q    <= wr_enable_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      stall_count0_q <= stall_count0_d;
      stall_count1_q <= stall_count1_d;
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.wr_enable  = wr_enable_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign last_grant     = last_grant_q;
  assign stall_count0   = stall_count0_q;
  assign stall_count1   = stall_count1_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed scoreboard bench: each step pushes the hand-computed post-edge state, a monitor checks it.
module tb_regfile_write_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;

  logic clk;
  logic reset_n;
  logic hold;
  logic count_clear;
  logic last_grant;
  logic [CW-1:0] stall_count0;
  logic [CW-1:0] stall_count1;

  regfile_write_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  regfile_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .hold         (hold),
    .count_clear  (count_clear),
    .bus          (bus),
    .last_grant   (last_grant),
    .stall_count0 (stall_count0),
    .stall_count1 (stall_count1)
  );

  typedef struct {
    logic          en;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          lg;
    logic [CW-1:0] s0;
    logic [CW-1:0] s1;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // One cycle: drive at negedge, check combinational readies, queue expected post-edge state.
  task automatic step(input logic h, input logic clr,
                      input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                      input logic r0, input logic r1,
                      input logic en, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic lg, input logic [CW-1:0] s0, input logic [CW-1:0] s1);
    exp_t e;
    @(negedge clk);
    hold = h; count_clear = clr;
    bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_data = d0;
    bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_data = d1;
    #2;
    chk("req0_ready", {31'd0, bus.req0_ready}, {31'd0, r0});
    chk("req1_ready", {31'd0, bus.req1_ready}, {31'd0, r1});
    e.en = en; e.wa = wa; e.wd = wd; e.lg = lg; e.s0 = s0; e.s1 = s1;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_enable",    {31'd0, bus.wr_enable}, {31'd0, e.en});
        chk("wr_addr",      {27'd0, bus.wr_addr},   {27'd0, e.wa});
        chk("wr_data",      bus.wr_data,            e.wd);
        chk("last_grant",   {31'd0, last_grant},    {31'd0, e.lg});
        chk("stall_count0", {28'd0, stall_count0},  {28'd0, e.s0});
        chk("stall_count1", {28'd0, stall_count1},  {28'd0, e.s1});
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check_reset_state();
    chk("rst wr_enable",    {31'd0, bus.wr_enable},  32'd0);
    chk("rst wr_addr",      {27'd0, bus.wr_addr},    32'd0);
    chk("rst wr_data",      bus.wr_data,             32'd0);
    chk("rst last_grant",   {31'd0, last_grant},     32'd0);
    chk("rst stall_count0", {28'd0, stall_count0},   32'd0);
    chk("rst stall_count1", {28'd0, stall_count1},   32'd0);
    chk("rst req0_ready",   {31'd0, bus.req0_ready}, 32'd0);
    chk("rst req1_ready",   {31'd0, bus.req1_ready}, 32'd0);
  endtask

  initial begin : driver
    reset_n = 1'b0; hold = 1'b0; count_clear = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
    #1;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    #1;
    check_reset_state();
    @(negedge clk);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    reset_n = 1'b1;

    // idle after reset
    for (int i = 0; i < 5; i++)
      step(0,0, 0,5'd0,32'h0, 0,5'd0,32'h0, 0,0, 0,5'd0,32'h0, 0,4'd0,4'd0);

    // single requester 0
    step(0,0, 1,5'd5,32'hDEADBEEF, 0,5'd0,32'h0, 1,0, 1,5'd5,32'hDEADBEEF, 0,4'd0,4'd0);

    // async reset while the write sits in the output stage
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd6; bus.req0_data = 32'h66;
    reset_n = 1'b0;
    #1;
    check_reset_state();
    @(negedge clk);
    bus.req0_valid = 1'b0;
    reset_n = 1'b1;

    // sustained contention from prio=0: grants 0,1,0,1
    step(0,0, 1,5'd3,32'h30, 1,5'd6,32'h60, 1,0, 1,5'd3,32'h30, 0,4'd0,4'd1);
    step(0,0, 1,5'd4,32'h40, 1,5'd6,32'h60, 0,1, 1,5'd6,32'h60, 1,4'd1,4'd1);
    step(0,0, 1,5'd4,32'h40, 1,5'd7,32'h70, 1,0, 1,5'd4,32'h40, 0,4'd1,4'd2);
    step(0,0, 1,5'd8,32'h80, 1,5'd7,32'h70, 0,1, 1,5'd7,32'h70, 1,4'd2,4'd2);
    step(0,0, 0,5'd0,32'h0,  0,5'd0,32'h0,  0,0, 0,5'd7,32'h70, 1,4'd2,4'd2);

    // x0 discard by requester 1 after prio moved to 1, then prove prio is back at 0
    step(0,0, 1,5'd9,32'h90, 0,5'd0,32'h0,    1,0, 1,5'd9,32'h90,   0,4'd2,4'd2);
    step(0,0, 0,5'd0,32'h0,  1,5'd0,32'h1234, 0,1, 0,5'd0,32'h1234, 1,4'd2,4'd2);
    step(0,0, 1,5'd10,32'hA, 1,5'd11,32'hB,   1,0, 1,5'd10,32'hA,   0,4'd2,4'd3);
    step(0,0, 0,5'd0,32'h0,  1,5'd11,32'hB,   0,1, 1,5'd11,32'hB,   1,4'd2,4'd3);

    // hold with clear
    step(0,1, 0,5'd0,32'h0, 0,5'd0,32'h0,  0,0, 0,5'd11,32'hB, 1,4'd0,4'd0);
    step(1,0, 0,5'd0,32'h0, 1,5'd12,32'hC, 0,0, 0,5'd11,32'hB, 1,4'd0,4'd1);
    step(1,0, 0,5'd0,32'h0, 1,5'd12,32'hC, 0,0, 0,5'd11,32'hB, 1,4'd0,4'd2);
    step(1,0, 0,5'd0,32'h0, 1,5'd12,32'hC, 0,0, 0,5'd11,32'hB, 1,4'd0,4'd3);
    step(1,1, 0,5'd0,32'h0, 1,5'd12,32'hC, 0,0, 0,5'd11,32'hB, 1,4'd0,4'd0);
    step(0,0, 0,5'd0,32'h0, 1,5'd12,32'hC, 0,1, 1,5'd12,32'hC, 1,4'd0,4'd0);

    // grant, then hold mid-stream and saturate requester 0's counter
    step(0,0, 1,5'd13,32'hD, 0,5'd0,32'h0, 1,0, 1,5'd13,32'hD, 0,4'd0,4'd0);
    for (int i = 1; i <= 20; i++)
      step(1,0, 1,5'd14,32'hE, 0,5'd0,32'h0, 0,0, 0,5'd13,32'hD, 0,
           (i > 15) ? 4'd15 : 4'(i), 4'd0);
    step(0,0, 1,5'd14,32'hE, 0,5'd0,32'h0, 1,0, 1,5'd14,32'hE, 0,4'd15,4'd0);
    step(0,1, 0,5'd0,32'h0,  0,5'd0,32'h0, 0,0, 0,5'd14,32'hE, 0,4'd0,4'd0);

    begin : drain
      int budget;
      budget = 10;
      while (exp_q.size() != 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      #2;
      if (exp_q.size() != 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register file's single write port between two writeback requesters: requester 0 is execute/ALU results and requester 1 is memory load data. It arbitrates round-robin with valid/ready handshakes and registers the winning write for one cycle. It drives the register file's write-enable, write-address and write-data inputs directly. Writes to x0 are accepted and discarded, and per-requester stall counters support performance debug.

## Interface
Parameters:
- DATA_WIDTH, 32, width of write data
- ADDR_WIDTH, 5, width of register address (32 registers)
- CNT_WIDTH, 16, width of each stall counter

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- hold  in  1  pipeline freeze; when 1, no grants are issued
- count_clear  in  1  synchronous clear of both stall counters
- req0_valid  in  1  requester 0 (execute) has a write
- req0_addr  in  ADDR_WIDTH  destination register of requester 0
- req0_data  in  DATA_WIDTH  write value of requester 0
- req0_ready  out  1  requester 0 write accepted this cycle (combinational)
- req1_valid  in  1  requester 1 (load) has a write
- req1_addr  in  ADDR_WIDTH  destination register of requester 1
- req1_data  in  DATA_WIDTH  write value of requester 1
- req1_ready  out  1  requester 1 write accepted this cycle (combinational)
- wr_enable  out  1  register file write enable (registered)
- wr_addr  out  ADDR_WIDTH  register file write address (registered)
- wr_data  out  DATA_WIDTH  register file write data (registered)
- last_grant  out  1  requester that won most recently (registered)
- stall_count0  out  CNT_WIDTH  cycles requester 0 was valid but not ready
- stall_count1  out  CNT_WIDTH  same for requester 1

## Operation
- Handshake: a transfer occurs on a rising edge where reqN_valid and reqN_ready are both 1.
  - Requester must hold valid, addr and data stable until accepted.
  - readyN must not depend on anything other than hold, both valids and the priority pointer.
- Arbitration state: a 1-bit priority pointer `prio`, reset 0 (favours requester 0).
- Grant rules, evaluated only when hold=0:
  - Only req0_valid: grant 0.
  - Only req1_valid: grant 1.
  - Both valid: grant `prio`.
  - Neither valid: no grant.
- At most one readyN is 1 per cycle. Both are 0 when hold=1.
- Pointer update: after any grant to requester k, `prio` becomes the other requester (1-k). The pointer holds when there is no grant.
- last_grant mirrors the most recent winner. It equals 0 after reset.
- Output stage, on each edge:
  - With a grant: wr_addr and wr_data load the winner's addr and data. wr_enable loads 1 if addr != 0, else 0.
  - Without a grant: wr_enable loads 0, and wr_addr and wr_data hold their values.
- x0 writes complete the handshake normally, still advance `prio`, and produce wr_enable=0.
- Both requesters targeting the same address: they serialize in grant order, and the later write wins in the register file. Ordering across requesters is the upstream pipeline's responsibility.
- Stall counters:
  - stall_countN increments when reqN_valid=1 and reqN_ready=0, including while hold=1.
  - Counters saturate at all-ones and do not wrap.
  - count_clear=1 loads 0 and takes priority over increment.

## Timing
- Reset (asynchronous, while reset_n=0):
  - wr_enable=0, wr_addr=0, wr_data=0.
  - prio=0, last_grant=0.
  - stall_count0=stall_count1=0.
  - req0_ready and req1_ready are forced 0.
- Latency: a write accepted at edge T appears on wr_* during cycle T..T+1. The register file captures it at edge T+1, so two edges from handshake to register update.
- Throughput: one write per cycle. Under sustained contention the requesters alternate, 50% each.
- hold asserted mid-stream:
  - No new grant.
  - wr_enable drops to 0 after the next edge.
  - A write already in the output stage still completes.
- reset_n asserted mid-operation: the pending output write is lost and wr_enable is forced to 0 immediately.
- Deassertion of reset_n must be synchronized externally to clk.

## Test plan
- Reset then idle: both valids 0 for 5 cycles -> wr_enable=0 throughout; all counters 0; last_grant=0.
- Single requester: req0 writes addr 5, data 0xDEADBEEF -> req0_ready=1 that cycle; next cycle wr_enable=1, wr_addr=5, wr_data=0xDEADBEEF.
- Contention: both valid continuously for 4 cycles after reset -> grants 0,1,0,1; stall_count0=2, stall_count1=2; wr_addr sequence matches.
- x0 discard: req1 writes addr 0, data 0x1234 -> req1_ready=1; next cycle wr_enable=0; prio flips to 0.
- Hold and clear: req1 valid, hold=1 for 3 cycles -> req1_ready=0 and stall_count1=3; then count_clear=1 with valid still high -> stall_count1=0 next cycle.
- Saturation (CNT_WIDTH=4): req0 stalled by hold for 20 cycles -> stall_count0 stops at 15.
